// File: rtl/mem_pkg.sv
// Shared types and widths for the block memory responder.
package mem_pkg;

    localparam int BLOCK_W    = 128;
    localparam int MEM_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Block storage: one synchronous write port, one read port captured into rdata.
module mem_array
    import mem_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [BLOCK_W-1:0] wdata,
    input  logic               re,
    input  logic [IDX_W-1:0]   raddr,
    output logic [BLOCK_W-1:0] rdata
);

    localparam int DEPTH = 1 << IDX_W;

    // Contents deliberately survive reset; only the read register clears.
    logic [BLOCK_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency block memory responder with request latching, completion
// pulse, saturating read/write statistics and a sticky protocol error flag.
//
// state | meaning
// IDLE  | waiting for mem_read / mem_write
// BUSY  | request latched, latency counter running down
// RESP  | mem_ready high for this cycle, back to IDLE next edge
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [BLOCK_W-1:0]    mem_wdata,
    output logic [BLOCK_W-1:0]    mem_rdata,
    output logic                  mem_ready,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  proto_err
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t             state;
    logic [7:0]         cnt;
    logic [IDX_W-1:0]   addr_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic               op_write_q;
    logic               enter_resp;
    logic               arr_we;
    logic               arr_re;

    // Upper address bits alias onto the same block by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[MEM_ADDR_W-1:IDX_W];

    assign enter_resp = (state == BUSY) && (cnt == 8'd0);
    // Gated by rst_n so a reset landing on the RESP entry edge aborts the write.
    assign arr_we     = rst_n && enter_resp && op_write_q;
    assign arr_re     = rst_n && enter_resp && !op_write_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            mem_ready  <= 1'b0;
            rd_count   <= 16'd0;
            wr_count   <= 16'd0;
            proto_err  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q     <= mem_addr[IDX_W-1:0];
                        wdata_q    <= mem_wdata;
                        op_write_q <= mem_write;
                        cnt        <= CNT_LOAD;
                        state      <= BUSY;
                        if (mem_read && mem_write) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        if (op_write_q) begin
                            wr_count <= sat_inc(wr_count);
                        end else begin
                            rd_count <= sat_inc(rd_count);
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .re    (arr_re),
        .raddr (addr_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_mem_responder;
    import mem_pkg::*;

    localparam logic [127:0] D_BEEF = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;
    localparam logic [127:0] D_A    = 128'hAAAA_5555_AAAA_5555_1111_2222_3333_4444;
    localparam logic [127:0] D_B    = 128'hBBBB_0000_CCCC_0000_DDDD_0000_EEEE_0001;
    localparam logic [127:0] D_X    = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [127:0] D_Y    = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    localparam logic [127:0] D_E    = 128'h0E0E_0E0E_0E0E_0E0E_0E0E_0E0E_0E0E_0E0E;
    localparam logic [127:0] D_Z    = 128'h1234_0000_0000_0000_0000_0000_0000_5678;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         a_read, a_write, a_ready, a_perr;
    logic [27:0]  a_addr;
    logic [127:0] a_wdata, a_rdata;
    logic [15:0]  a_rd, a_wr;

    logic         b_read, b_write, b_ready, b_perr;
    logic [27:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;
    logic [15:0]  b_rd, b_wr;

    int total = 0;
    int bad   = 0;

    mem_responder #(.LATENCY(4), .IDX_W(6)) dut4 (
        .clk(clk), .rst_n(rst_n), .mem_read(a_read), .mem_write(a_write),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
        .mem_ready(a_ready), .rd_count(a_rd), .wr_count(a_wr), .proto_err(a_perr)
    );

    mem_responder #(.LATENCY(1), .IDX_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(b_read), .mem_write(b_write),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .mem_ready(b_ready), .rd_count(b_rd), .wr_count(b_wr), .proto_err(b_perr)
    );

    // One transaction on dut4. lat = edges after acceptance until ready seen
    // (-1 if never). Inputs are scrambled while busy; the latched copy must win.
    task automatic a_txn(input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [127:0] data, output int lat, output logic wide_ok,
                         output logic [127:0] rdata);
        lat = -1;
        wide_ok = 1'b0;
        rdata = '0;
        @(negedge clk);
        a_read = rd; a_write = wr; a_addr = addr; a_wdata = data;
        @(negedge clk);
        a_addr = ~addr; a_wdata = ~data;
        for (int k = 0; k < 40; k++) begin
            if (a_ready) begin
                lat = k;
                rdata = a_rdata;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        wide_ok = (lat >= 0) && !a_ready;
        a_read = 1'b0; a_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_read = 0; a_write = 0; a_addr = '0; a_wdata = '0;
        b_read = 0; b_write = 0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({a_ready, a_perr, a_rd, a_wr} !== 34'd0) begin
            bad++;
            $display("FAIL reset_a got ready=%b perr=%b rd=%0d wr=%0d want all 0", a_ready, a_perr, a_rd, a_wr);
        end
        total++;
        if (a_rdata !== 128'd0) begin
            bad++;
            $display("FAIL reset_rdata got %h want 0", a_rdata);
        end
        total++;
        if ({b_ready, b_perr, b_rd, b_wr} !== 34'd0 || b_rdata !== 128'd0) begin
            bad++;
            $display("FAIL reset_b got ready=%b perr=%b rd=%0d wr=%0d want all 0", b_ready, b_perr, b_rd, b_wr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat; logic w; logic [127:0] rd;
        a_txn(1'b0, 1'b1, 28'h0000005, D_BEEF, lat, w, rd);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL wr_latency got %0d want 4", lat); end
        total++;
        if (w !== 1'b1) begin bad++; $display("FAIL wr_ready_width got %b want 1", w); end
        total++;
        if (a_wr !== 16'd1) begin bad++; $display("FAIL wr_count got %0d want 1", a_wr); end
        a_txn(1'b1, 1'b0, 28'h0000005, '0, lat, w, rd);
        total++;
        if (lat !== 4 || w !== 1'b1) begin bad++; $display("FAIL rd_latency got lat=%0d wide_ok=%b want 4/1", lat, w); end
        total++;
        if (rd !== D_BEEF) begin bad++; $display("FAIL rd_data got %h want %h", rd, D_BEEF); end
        total++;
        if (a_rd !== 16'd1 || a_wr !== 16'd1) begin bad++; $display("FAIL rd_count got rd=%0d wr=%0d want 1/1", a_rd, a_wr); end
    endtask

    task automatic test_alias();
        int lat; logic w; logic [127:0] rd;
        a_txn(1'b0, 1'b1, 28'h0000041, D_A, lat, w, rd);
        a_txn(1'b1, 1'b0, 28'h0000001, '0, lat, w, rd);
        total++;
        if (rd !== D_A) begin bad++; $display("FAIL alias_data got %h want %h", rd, D_A); end
        total++;
        if (a_perr !== 1'b0) begin bad++; $display("FAIL alias_perr got %b want 0", a_perr); end
        a_txn(1'b0, 1'b1, 28'h0000008, D_Z, lat, w, rd);
        total++;
        if (a_rdata !== D_A) begin bad++; $display("FAIL rdata_hold got %h want %h", a_rdata, D_A); end
        total++;
        if (a_rd !== 16'd2 || a_wr !== 16'd3) begin bad++; $display("FAIL alias_counts got rd=%0d wr=%0d want 2/3", a_rd, a_wr); end
    endtask

    task automatic test_proto_err();
        int lat; logic w; logic [127:0] rd;
        a_txn(1'b1, 1'b1, 28'h0000002, D_B, lat, w, rd);
        total++;
        if (lat !== 4 || a_perr !== 1'b1) begin bad++; $display("FAIL proto_set got lat=%0d perr=%b want 4/1", lat, a_perr); end
        total++;
        if (a_wr !== 16'd4 || a_rd !== 16'd2) begin bad++; $display("FAIL proto_as_write got rd=%0d wr=%0d want 2/4", a_rd, a_wr); end
        a_txn(1'b1, 1'b0, 28'h0000002, '0, lat, w, rd);
        total++;
        if (rd !== D_B) begin bad++; $display("FAIL proto_data got %h want %h", rd, D_B); end
        total++;
        if (a_perr !== 1'b1) begin bad++; $display("FAIL proto_sticky got %b want 1", a_perr); end
    endtask

    task automatic test_back_to_back();
        int cyc = 0, n_ready = 0, last = -1, gap_bad = 0, data_bad = 0, first = -1, issued = 1;
        bit seen = 0;
        @(negedge clk);
        b_write = 1'b1; b_addr = 28'h7; b_wdata = D_E;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b_ready) begin seen = 1; break; end
        end
        b_write = 1'b0;
        total++;
        if (!seen) begin bad++; $display("FAIL b2b_prewrite got no ready want ready"); end
        @(negedge clk);
        @(negedge clk);
        b_read = 1'b1; b_addr = 28'h7;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            cyc++;
            if (b_ready) begin
                n_ready++;
                if (first < 0) first = cyc;
                if (last >= 0 && cyc - last != 3) gap_bad++;
                if (b_rdata !== D_E) data_bad++;
                last = cyc;
                b_read = 1'b0;
            end else if (!b_read && issued < 4 && last == cyc - 1) begin
                b_read = 1'b1;
                issued++;
            end
        end
        total++;
        if (first !== 2) begin bad++; $display("FAIL b2b_first got %0d want 2", first); end
        total++;
        if (n_ready !== 4) begin bad++; $display("FAIL b2b_pulses got %0d want 4", n_ready); end
        total++;
        if (gap_bad !== 0) begin bad++; $display("FAIL b2b_spacing got %0d bad gaps want 0", gap_bad); end
        total++;
        if (data_bad !== 0) begin bad++; $display("FAIL b2b_data got %0d bad reads want 0", data_bad); end
        total++;
        if (b_rd !== 16'd4 || b_wr !== 16'd1) begin bad++; $display("FAIL b2b_counts got rd=%0d wr=%0d want 4/1", b_rd, b_wr); end
    endtask

    task automatic test_reset_abort();
        int lat; logic w; logic [127:0] rd;
        int spurious = 0;
        a_txn(1'b0, 1'b1, 28'h0000009, D_X, lat, w, rd);
        @(negedge clk);
        a_write = 1'b1; a_addr = 28'h0000009; a_wdata = D_Y;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; a_write = 1'b0;
        // Reset covers edges t0+2..t0+4, including the would-be RESP entry.
        repeat (3) begin
            @(negedge clk);
            if (a_ready) spurious++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (a_ready) spurious++;
        end
        total++;
        if (spurious !== 0) begin bad++; $display("FAIL abort_ready got %0d pulses want 0", spurious); end
        total++;
        if (a_rd !== 16'd0 || a_wr !== 16'd0 || a_perr !== 1'b0) begin
            bad++; $display("FAIL abort_clear got rd=%0d wr=%0d perr=%b want 0/0/0", a_rd, a_wr, a_perr);
        end
        a_txn(1'b1, 1'b0, 28'h0000009, '0, lat, w, rd);
        total++;
        if (rd !== D_X) begin bad++; $display("FAIL abort_olddata got %h want %h", rd, D_X); end
        total++;
        if (lat !== 4 || a_rd !== 16'd1) begin bad++; $display("FAIL abort_after got lat=%0d rd=%0d want 4/1", lat, a_rd); end
    endtask

    task automatic test_saturation();
        int lat; logic w; logic [127:0] rd;
        @(negedge clk);
        force dut4.wr_count = 16'hFFFE;
        @(negedge clk);
        release dut4.wr_count;
        @(negedge clk);
        total++;
        if (a_wr !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got %h want fffe", a_wr); end
        a_txn(1'b0, 1'b1, 28'h0000010, D_Z, lat, w, rd);
        total++;
        if (a_wr !== 16'hFFFF) begin bad++; $display("FAIL sat_first got %h want ffff", a_wr); end
        a_txn(1'b0, 1'b1, 28'h0000011, D_Z, lat, w, rd);
        total++;
        if (a_wr !== 16'hFFFF) begin bad++; $display("FAIL sat_second got %h want ffff", a_wr); end
        a_txn(1'b0, 1'b1, 28'h0000012, D_Z, lat, w, rd);
        total++;
        if (a_wr !== 16'hFFFF || a_rd !== 16'd1) begin bad++; $display("FAIL sat_third got wr=%h rd=%0d want ffff/1", a_wr, a_rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_proto_err();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to mem_ready; legal range 1..255.
REQ-002 Parameter IDX_W, default 6, block-index bits used from mem_addr; storage is 2^IDX_W blocks x 128 b.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 mem_read  input  1  block read request, held high until the cycle after mem_ready.
REQ-006 mem_write  input  1  block write request, same holding rule as mem_read.
REQ-007 mem_addr  input  28  block address (word address >> 2).
REQ-008 mem_wdata  input  128  write block, valid while mem_write high.
REQ-009 mem_rdata  output  128  read block, valid while mem_ready high for a read.
REQ-010 mem_ready  output  1  one-cycle completion pulse.
REQ-011 rd_count  output  16  completed reads, saturating.
REQ-012 wr_count  output  16  completed writes, saturating.
REQ-013 proto_err  output  1  sticky flag, protocol violation seen.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-015 In IDLE, mem_read or mem_write high at an edge SHALL be accepted: latch addr, wdata, op; load cnt=LATENCY-1; go BUSY.
REQ-016 mem_read and mem_write both high at acceptance SHALL be serviced as a write and SHALL set proto_err.
REQ-017 In BUSY, cnt==0 at an edge SHALL go RESP; otherwise cnt decrements.
REQ-018 Acceptance at edge t0 SHALL raise mem_ready for exactly the cycle after edge t0+LATENCY; RESP always returns to IDLE next edge.
REQ-019 Writes SHALL commit latched wdata to array[addr[IDX_W-1:0]] at the edge entering RESP.
REQ-020 Reads SHALL load mem_rdata from array[addr[IDX_W-1:0]] at the edge entering RESP; mem_rdata holds until the next read response.
REQ-021 Address bits [27:IDX_W] SHALL be ignored (aliasing), no error raised.
REQ-022 Request inputs and mem_wdata changes during BUSY/RESP SHALL be ignored; only the latched copy is used.
REQ-023 A request still high in IDLE the cycle after RESP SHALL be accepted as new; requester drops it per REQ-005.
REQ-024 rd_count/wr_count SHALL increment at the edge entering RESP, saturating at 16'hFFFF.
REQ-025 mem_ready, mem_rdata, counters, proto_err SHALL be registered outputs; no input-to-output combinational path.

Reset
REQ-026 rst_n low at an edge SHALL force IDLE, cnt=0, mem_ready=0, mem_rdata=0, rd_count=0, wr_count=0, proto_err=0.
REQ-027 Reset mid-transaction SHALL abort it: no array write, no mem_ready pulse, no counter update.
REQ-028 Array contents SHALL NOT be cleared by reset.

Structure
REQ-029 Shared package mem_pkg SHALL hold BLOCK_W=128, MEM_ADDR_W=28, and the state enum {IDLE, BUSY, RESP}.
REQ-030 Storage SHALL be a sub-module mem_array (1 read/1 write port, synchronous write, read captured at the RESP entry edge); FSM, counter, stats stay in mem_responder.

Verification
REQ-031 LATENCY=4: write addr 0x0000005, data 0x...DEADBEEF, then read 0x0000005 -> each mem_ready exactly 4 cycles after acceptance, 1 cycle wide; read returns 0x...DEADBEEF; wr_count=1, rd_count=1.
REQ-032 LATENCY=1: back-to-back read requests (request dropped one cycle after ready, reasserted) -> ready every 3 cycles, no double service, counters match request count.
REQ-033 IDX_W=6: write 0x0000041 data A, read 0x0000001 -> returns A (aliasing); proto_err stays 0.
REQ-034 mem_read and mem_write high together, addr 0x2, data B -> write performed, proto_err=1 sticky until reset; later read 0x2 returns B.
REQ-035 Write accepted, rst_n low 2 cycles later, then read same address -> no mem_ready during reset, old array data returned, counters=0 after reset.
REQ-036 Force wr_count to 16'hFFFE via 3 writes with preload/backdoor -> saturates at 16'hFFFF, no wrap.
